// File: rtl/ssc_host_uart_if.sv
// Host-side byte streams and status of the SSC serial endpoint.
// The host framework is the master; the UART endpoint is the slave.
interface ssc_host_uart_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       RX_OVERRUN;
  logic       RX_FRAME_ERR;
  logic       ERR_CLR;
  logic       TX_BUSY;

  modport master (
    output TX_DATA, TX_VALID, RX_READY, ERR_CLR,
    input  TX_READY, RX_DATA, RX_VALID, RX_OVERRUN, RX_FRAME_ERR, TX_BUSY
  );
  modport slave (
    input  TX_DATA, TX_VALID, RX_READY, ERR_CLR,
    output TX_READY, RX_DATA, RX_VALID, RX_OVERRUN, RX_FRAME_ERR, TX_BUSY
  );
endinterface

// File: rtl/ssc_host_uart.sv
// Framework-side 8N1 serial endpoint facing the Super Serial Card's 6551 pins:
// RX deserializer + FIFO toward the host, TX FIFO + serializer toward the card.
module ssc_fifo #(
  parameter int AW = 4
) (
  input  logic          CLK_14M,
  input  logic          RESET,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic [AW:0]   count,
  output logic          full
);
  logic [7:0]  mem [0:(1<<AW)-1];
  logic [AW:0] wptr, rptr;
  logic        wr, rd;

  assign count = wptr - rptr;
  assign full  = count[AW];
  assign rd    = pop & (count != '0);
  // a pop in the same cycle frees the slot, so a push into a full FIFO is fine then
  assign wr    = push & (~full | rd);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge CLK_14M)
    if (wr) mem[wptr[AW-1:0]] <= wdata;
endmodule

module ssc_host_uart #(
  parameter int CLKS_PER_BIT = 1491,
  parameter int FIFO_AW      = 4,
  parameter int CTS_MARGIN   = 4
) (
  input  logic CLK_14M,
  input  logic RESET,
  input  logic SSC_TXD,
  output logic SSC_RXD,
  input  logic SSC_RTS,
  output logic SSC_CTS,
  output logic SSC_DSR,
  ssc_host_uart_if.slave host
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]      BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0]   CTS_LIM  = (FIFO_AW+1)'((1 << FIFO_AW) - CTS_MARGIN - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_st_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_t;

  logic txd_s1, txd_s2, txd_prev, rts_s1, rts_s2;

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      txd_s1 <= 1'b1; txd_s2 <= 1'b1; txd_prev <= 1'b1;
      rts_s1 <= 1'b1; rts_s2 <= 1'b1;
    end else begin
      txd_s1 <= SSC_TXD; txd_s2 <= txd_s1; txd_prev <= txd_s2;
      rts_s1 <= SSC_RTS; rts_s2 <= rts_s1;
    end
  end

  // FIFOs
  logic [7:0]       tx_rdata, rx_rdata, rx_sh, tx_sh;
  logic [FIFO_AW:0] tx_count, rx_count;
  logic             tx_full, rx_full, tx_pop, rx_push;

  ssc_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .CLK_14M(CLK_14M), .RESET(RESET),
    .push(host.TX_VALID & ~tx_full), .wdata(host.TX_DATA),
    .pop(tx_pop), .rdata(tx_rdata), .count(tx_count), .full(tx_full)
  );

  ssc_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .CLK_14M(CLK_14M), .RESET(RESET),
    .push(rx_push), .wdata(rx_sh),
    .pop(host.RX_READY), .rdata(rx_rdata), .count(rx_count), .full(rx_full)
  );

  assign host.TX_READY = ~tx_full;
  assign host.RX_VALID = (rx_count != '0);
  assign host.RX_DATA  = rx_rdata;
  assign SSC_DSR       = 1'b0;

  // RX deserializer
  rx_st_t        rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic          rx_stop_smp, rx_ovr, rx_ferr;

  assign rx_stop_smp = (rx_st == RX_STOP) && (rx_cnt == BIT_END);
  assign rx_push     = rx_stop_smp & txd_s2;

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      rx_st <= RX_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
    end else begin
      rx_cnt <= rx_cnt + 1'b1;
      case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (txd_prev & ~txd_s2) rx_st <= RX_START;
        end
        RX_START: if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= txd_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt <= '0;
          rx_sh  <= {txd_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_st <= RX_STOP;
        end
        RX_STOP: if (rx_cnt == BIT_END) begin
          rx_cnt <= '0;
          rx_st  <= txd_s2 ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: begin
          rx_cnt <= '0;
          if (txd_s2) rx_st <= RX_IDLE;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // sticky flags: a set event in the same cycle as ERR_CLR wins
  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      rx_ovr  <= 1'b0;
      rx_ferr <= 1'b0;
      SSC_CTS <= 1'b1;
    end else begin
      rx_ovr  <= (rx_push & rx_full & ~host.RX_READY) | (rx_ovr & ~host.ERR_CLR);
      rx_ferr <= (rx_stop_smp & ~txd_s2) | (rx_ferr & ~host.ERR_CLR);
      SSC_CTS <= (rx_count > CTS_LIM);
    end
  end

  assign host.RX_OVERRUN   = rx_ovr;
  assign host.RX_FRAME_ERR = rx_ferr;

  // TX serializer; RTS only gates the start of a byte
  tx_st_t        tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic          tx_line, tx_busy;

  assign tx_pop = (tx_count != '0) & ~rts_s2 &
                  ((tx_st == TX_IDLE) || ((tx_st == TX_STOP) && (tx_cnt == BIT_END)));

  always_comb begin
    tx_line = 1'b1;
    case (tx_st)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_sh[0];
      default:  tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      tx_st <= TX_IDLE; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '0;
      SSC_RXD <= 1'b1; tx_busy <= 1'b0;
    end else begin
      tx_cnt  <= tx_cnt + 1'b1;
      SSC_RXD <= tx_line;
      tx_busy <= (tx_st != TX_IDLE);
      case (tx_st)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_st <= TX_START;
            tx_sh <= tx_rdata;
          end
        end
        TX_START: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          tx_bit <= '0;
          tx_st  <= TX_DATA;
        end
        TX_DATA: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          tx_sh  <= {1'b0, tx_sh[7:1]};
          tx_bit <= tx_bit + 1'b1;
          if (tx_bit == 3'd7) tx_st <= TX_STOP;
        end
        TX_STOP: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_st <= TX_START;
            tx_sh <= tx_rdata;
          end else begin
            tx_st <= TX_IDLE;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  assign host.TX_BUSY = tx_busy;
endmodule

// File: tb/tb_ssc_host_uart.sv
// Randomized bench for ssc_host_uart with a short bit period; a line monitor
// decodes TX frames and queues model the RX FIFO contents and flags.
module tb_ssc_host_uart;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int FR   = 10 * CPB;
  // sync (2) + edge detect (1) + half bit + 8 data bits + stop sample
  localparam int RV_LAT = 3 + HALF + 9 * CPB;

  logic CLK_14M = 1'b0, RESET = 1'b1, txd_drv = 1'b1, loop = 1'b0, SSC_RTS = 1'b1;
  logic SSC_RXD, SSC_CTS, SSC_DSR, ssc_txd;
  int   cyc = 0, rv_rise = 0, n_cmp = 0, n_bad = 0;
  logic rv_q = 1'b0;

  logic [7:0] b, r;
  int         st, bad, n, prev, lows, st0;
  logic       ovr_exp;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  ssc_host_uart_if host();
  assign ssc_txd = loop ? SSC_RXD : txd_drv;

  ssc_host_uart #(.CLKS_PER_BIT(CPB), .FIFO_AW(4), .CTS_MARGIN(4)) dut (
    .CLK_14M(CLK_14M), .RESET(RESET), .SSC_TXD(ssc_txd), .SSC_RXD(SSC_RXD),
    .SSC_RTS(SSC_RTS), .SSC_CTS(SSC_CTS), .SSC_DSR(SSC_DSR), .host(host)
  );

  always #5 CLK_14M = ~CLK_14M;
  always @(posedge CLK_14M) cyc <= cyc + 1;
  always @(negedge CLK_14M) begin
    if (host.RX_VALID && !rv_q) rv_rise <= cyc;
    rv_q <= host.RX_VALID;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int k = 1);
    repeat (k) begin @(posedge CLK_14M); #1; end
  endtask

  task automatic send(input logic [7:0] d);
    chk("tx_ready", host.TX_READY, 1);
    host.TX_DATA = d; host.TX_VALID = 1'b1;
    tick();
    host.TX_VALID = 1'b0;
  endtask

  task automatic inj(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin txd_drv = f[i]; tick(CPB); end
  endtask

  task automatic pop_chk(input logic [7:0] exp);
    chk("rx_valid", host.RX_VALID, 1);
    chk("rx_data", host.RX_DATA, exp);
    host.RX_READY = 1'b1; tick(); host.RX_READY = 1'b0;
  endtask

  // decode one frame on SSC_RXD, checking every bit is held exactly CPB cycles
  task automatic mon(input int raise_at, output logic [7:0] d, output int s, output int nb);
    logic lvl;
    d = '0; nb = 0; s = -1; lvl = 1'b1;
    for (int w = 0; w < 4 * FR && SSC_RXD; w++) tick();
    if (SSC_RXD) begin nb = 1000; return; end
    s = cyc;
    for (int j = 0; j < FR; j++) begin
      if (j > 0) tick();
      if (j == raise_at) SSC_RTS = 1'b1;
      if (j % CPB == 0) begin
        lvl = SSC_RXD;
        if (j == 0 && SSC_RXD !== 1'b0) nb++;
        if (j == 9 * CPB && SSC_RXD !== 1'b1) nb++;
        if (j >= CPB && j < 9 * CPB) d[j / CPB - 1] = SSC_RXD;
      end else if (SSC_RXD !== lvl) nb++;
    end
  endtask

  initial begin
    host.TX_DATA = '0; host.TX_VALID = 1'b0; host.RX_READY = 1'b0; host.ERR_CLR = 1'b0;
    tick(3);
    chk("rst_rxd", SSC_RXD, 1);
    chk("rst_cts", SSC_CTS, 1);
    chk("rst_dsr", SSC_DSR, 0);
    chk("rst_rx_valid", host.RX_VALID, 0);
    chk("rst_ovr", host.RX_OVERRUN, 0);
    chk("rst_ferr", host.RX_FRAME_ERR, 0);
    chk("rst_busy", host.TX_BUSY, 0);
    chk("rst_tx_ready", host.TX_READY, 1);
    RESET = 1'b0; tick();
    chk("cts_after_rst", SSC_CTS, 0);
    SSC_RTS = 1'b0; tick(4);

    // single byte: start latency, bit widths, busy release
    send(8'h55); n = cyc;
    mon(-1, b, st, bad);
    chk("tx55_fall", st - n, 2);
    chk("tx55_bits", bad, 0);
    chk("tx55_byte", b, 8'h55);
    chk("tx55_busy_last", host.TX_BUSY, 1);
    tick();
    chk("tx55_busy_done", host.TX_BUSY, 0);

    // loopback: back-to-back frames, received in order
    SSC_RTS = 1'b1; tick(4); loop = 1'b1;
    txq = '{8'hA5, 8'h3C};
    for (int i = 0; i < 4; i++) txq.push_back(8'($urandom));
    foreach (txq[i]) send(txq[i]);
    SSC_RTS = 1'b0;
    prev = 0; st0 = 0;
    for (int k = 0; k < 6; k++) begin
      mon(-1, b, st, bad);
      chk("lb_bits", bad, 0);
      chk("lb_byte", b, txq[k]);
      if (k == 0) begin
        st0 = st;
        chk("lb_rv_latency", (rv_rise - st0 >= RV_LAT - 1) && (rv_rise - st0 <= RV_LAT + 1), 1);
      end else chk("lb_gap", st - prev, FR);
      prev = st;
    end
    tick(4); loop = 1'b0;
    foreach (txq[i]) pop_chk(txq[i]);
    chk("lb_rx_empty", host.RX_VALID, 0);
    chk("lb_ovr", host.RX_OVERRUN, 0);
    chk("lb_ferr", host.RX_FRAME_ERR, 0);

    // fill RX FIFO: CTS threshold and overrun
    rxq.delete(); ovr_exp = 1'b0;
    for (int i = 0; i < 17; i++) begin
      inj(8'(i), 1'b1);
      if (rxq.size() < 16) rxq.push_back(8'(i)); else ovr_exp = 1'b1;
      chk("fill_cts", SSC_CTS, rxq.size() >= 12);
      if (i >= 15) chk("fill_ovr", host.RX_OVERRUN, ovr_exp);
    end
    while (rxq.size() > 0) pop_chk(rxq.pop_front());
    chk("fill_empty", host.RX_VALID, 0);
    tick(2);
    chk("fill_cts_low", SSC_CTS, 0);
    host.ERR_CLR = 1'b1; tick(); host.ERR_CLR = 1'b0;
    chk("ovr_clr", host.RX_OVERRUN, 0);

    // framing error followed by a long break
    inj(8'h81, 1'b0);
    tick(200);
    chk("brk_ferr", host.RX_FRAME_ERR, 1);
    chk("brk_no_push", host.RX_VALID, 0);
    txd_drv = 1'b1; tick(4);
    host.ERR_CLR = 1'b1; tick(); host.ERR_CLR = 1'b0;
    chk("ferr_clr", host.RX_FRAME_ERR, 0);
    r = 8'($urandom);
    inj(r, 1'b1);
    pop_chk(r);

    // start-bit glitch is rejected, receiver still works afterwards
    txd_drv = 1'b0; tick(5); txd_drv = 1'b1; tick(3 * CPB);
    chk("glitch_no_push", host.RX_VALID, 0);
    chk("glitch_no_ferr", host.RX_FRAME_ERR, 0);
    r = 8'($urandom);
    inj(r, 1'b1);
    pop_chk(r);

    // RTS flow control: held while high, byte in flight completes
    SSC_RTS = 1'b1; tick(4);
    txq.delete();
    for (int i = 0; i < 3; i++) begin txq.push_back(8'($urandom)); send(txq[i]); end
    lows = 0;
    for (int i = 0; i < 5 * CPB; i++) begin tick(); if (!SSC_RXD) lows++; end
    chk("rts_hold", lows, 0);
    chk("rts_hold_busy", host.TX_BUSY, 0);
    SSC_RTS = 1'b0;
    mon(4 * CPB, b, st, bad);
    chk("rts_b1_bits", bad, 0);
    chk("rts_b1", b, txq[0]);
    lows = 0;
    for (int i = 0; i < 3 * CPB; i++) begin tick(); if (!SSC_RXD) lows++; end
    chk("rts_hold2", lows, 0);
    SSC_RTS = 1'b0;
    mon(-1, b, st, bad);
    chk("rts_b2", b, txq[1]);
    prev = st;
    mon(-1, b, st, bad);
    chk("rts_b3", b, txq[2]);
    chk("rts_gap", st - prev, FR);

    // reset in the middle of a TX frame with RX data pending
    r = 8'($urandom);
    inj(r, 1'b1);
    chk("pre_rst_rx_valid", host.RX_VALID, 1);
    send(8'($urandom)); send(8'($urandom));
    for (int w = 0; w < 10 && SSC_RXD; w++) tick();
    tick(3 * CPB);
    RESET = 1'b1; tick();
    chk("mid_rst_rxd", SSC_RXD, 1);
    chk("mid_rst_tx_ready", host.TX_READY, 1);
    chk("mid_rst_rx_valid", host.RX_VALID, 0);
    chk("mid_rst_busy", host.TX_BUSY, 0);
    RESET = 1'b0;
    lows = 0;
    for (int i = 0; i < 2 * FR; i++) begin tick(); if (!SSC_RXD) lows++; end
    chk("post_rst_flushed", lows, 0);
    r = 8'($urandom);
    send(r);
    mon(-1, b, st, bad);
    chk("post_rst_bits", bad, 0);
    chk("post_rst_byte", b, r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
